// File: rtl/text_overlay_pkg.sv
// Shared constants and types for the text overlay renderer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package text_overlay_pkg;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 8;

  // Index 15 renders as an empty cell.
  localparam logic [3:0] CHAR_BLANK = 4'hF;

  // 8x8 font, one byte per glyph row, MSB is the leftmost pixel.
  // Glyphs 0..14 are the digits 0-9 and the letters A-E; glyph 15 is blank.
  localparam logic [7:0] FONT [16][8] = '{
    '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
    '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},
    '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
    '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00},
    '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
    '{8'h1C, 8'h30, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00},
    '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},
    '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00},
    '{8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E, 8'h66, 8'h66, 8'h00},
    '{8'h7C, 8'h66, 8'h66, 8'h7C, 8'h66, 8'h66, 8'h7C, 8'h00},
    '{8'h3C, 8'h66, 8'h60, 8'h60, 8'h60, 8'h66, 8'h3C, 8'h00},
    '{8'h78, 8'h6C, 8'h66, 8'h66, 8'h66, 8'h6C, 8'h78, 8'h00},
    '{8'h7E, 8'h60, 8'h60, 8'h7C, 8'h60, 8'h60, 8'h7E, 8'h00},
    '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}
  };

  // Stage-1 pipeline word: everything stage 2 needs to composite one pixel.
  typedef struct packed {
    logic       hit;   // pixel lies inside a text row band
    logic [2:0] grow;  // glyph row within the band
    logic [3:0] chr;   // character index (CHAR_BLANK when no cell / hidden)
    logic [2:0] xlo;   // pixel column within the cell
    logic [2:0] vid;   // underlay pixel, delayed to stay aligned
    logic [2:0] fg;    // glyph colour, delayed with its pixel
  } s1_t;

endpackage

// File: rtl/text_overlay_glyph_rom.sv
// Combinational 16x8 glyph lookup: character + row -> 8 pixel bits.
// Latency: 0 cycles (pure lookup).
// Backpressure: none; output follows inputs.
import text_overlay_pkg::*;

module char_glyph_rom (
  input  logic [3:0] chr,
  input  logic [2:0] rownum,
  output logic [7:0] pixels
);

  // Table lookup into the shared font.
  always_comb pixels = FONT[chr][rownum];

endmodule

// File: rtl/text_overlay.sv
// Text overlay: draws N_ROWS x N_CHARS glyph cells over the video underlay.
// Latency: 2 clk from x/y/vid_rgb to out_R/G/B and busy.
// Backpressure: none; one pixel accepted and produced every clock.
import text_overlay_pkg::*;

module text_overlay #(
  parameter int N_CHARS      = 8,
  parameter int N_ROWS       = 2,
  parameter int ROW_Y0       = 200,
  parameter int ROW_PITCH    = 9,
  parameter int COL0         = 1,
  parameter int COL_STEP     = 2,
  parameter int TRANSPARENT  = 0,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        newframe,
  input  logic [9:0]                  x,
  input  logic [9:0]                  y,
  input  logic [4*N_CHARS*N_ROWS-1:0] line,
  input  logic [N_ROWS-1:0]           blink_mask,
  input  logic [2:0]                  fg_rgb,
  input  logic [2:0]                  vid_rgb,
  output logic                        out_R,
  output logic                        out_G,
  output logic                        out_B,
  output logic                        busy
);

  localparam int LINE_W = 4 * N_CHARS * N_ROWS;
  // A one-frame half-period still needs a 1-bit counter to hold the wrap value.
  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [LINE_W-1:0] snap_line;
  logic [N_ROWS-1:0] snap_blink;
  logic [CNT_W-1:0]  frame_cnt;
  logic              blink_hidden;
  s1_t               s1_d;
  s1_t               s1_q;
  logic [7:0]        glyph_bits;
  logic              pix_on;
  logic [2:0]        pix_rgb;

  // Frame-synchronous copy of the text buffer; all-ones resets every cell to blank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_line  <= '1;
      snap_blink <= '0;
    end else if (newframe) begin
      snap_line  <= line;
      snap_blink <= blink_mask;
    end
  end

  // Blink half-period counter; phase flips each time the counter wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt    <= '0;
      blink_hidden <= 1'b0;
    end else if (newframe) begin
      if (frame_cnt == CNT_LAST) begin
        frame_cnt    <= '0;
        blink_hidden <= ~blink_hidden;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Stage 1 decode: row band, glyph row and character index for this pixel.
  // Rows are scanned from the top index down so the lowest matching row wins.
  always_comb begin
    s1_d     = '0;
    s1_d.chr = CHAR_BLANK;
    s1_d.xlo = x[2:0];
    s1_d.vid = vid_rgb;
    s1_d.fg  = fg_rgb;
    for (int r = N_ROWS - 1; r >= 0; r--) begin
      if ((int'(y) >= ROW_Y0 + r * ROW_PITCH) &&
          (int'(y) <  ROW_Y0 + r * ROW_PITCH + GLYPH_H)) begin
        s1_d.hit  = 1'b1;
        s1_d.grow = 3'(int'(y) - (ROW_Y0 + r * ROW_PITCH));
        s1_d.chr  = CHAR_BLANK;
        for (int k = 0; k < N_CHARS; k++) begin
          if (int'(x[9:3]) == COL0 + k * COL_STEP) begin
            s1_d.chr = snap_line[4 * (r * N_CHARS + k) +: 4];
          end
        end
        if (blink_hidden && snap_blink[r]) begin
          s1_d.chr = CHAR_BLANK;
        end
      end
    end
  end

  // Stage 1 register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) s1_q <= '0;
    else     s1_q <= s1_d;
  end

  char_glyph_rom u_rom (
    .chr    (s1_q.chr),
    .rownum (s1_q.grow),
    .pixels (glyph_bits)
  );

  // Stage 2 compositing: glyph colour, background, or plain underlay.
  always_comb begin
    pix_on  = glyph_bits[3'd7 - s1_q.xlo];
    pix_rgb = s1_q.vid;
    if (s1_q.hit) begin
      if (pix_on)                pix_rgb = s1_q.fg;
      else if (TRANSPARENT == 0) pix_rgb = 3'b000;
    end
  end

  // Stage 2 register drives the pixel outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {out_R, out_G, out_B} <= 3'b000;
      busy                  <= 1'b0;
    end else begin
      {out_R, out_G, out_B} <= pix_rgb;
      busy                  <= s1_q.hit;
    end
  end

endmodule

// File: tb/tb_text_overlay.sv
// Bench for text_overlay: opaque and transparent instances share stimulus.
// Latency: outputs compared against a 2-deep expected-value pipeline.
// Backpressure: none exercised; the pixel stream never stalls.
import text_overlay_pkg::*;

module tb_text_overlay;

  localparam int NC = 8, NR = 2, Y0 = 200, PITCH = 9, C0 = 1, CSTEP = 2;
  localparam int BF0 = 2, BF1 = 3;
  localparam int LW = 4 * NC * NR;

  logic          clk = 1'b0;
  logic          rst;
  logic          newframe;
  logic [9:0]    x, y;
  logic [LW-1:0] line;
  logic [NR-1:0] blink_mask;
  logic [2:0]    fg_rgb, vid_rgb;
  logic          r0, g0, b0, busy0;
  logic          r1, g1, b1, busy1;

  text_overlay #(.N_CHARS(NC), .N_ROWS(NR), .ROW_Y0(Y0), .ROW_PITCH(PITCH),
                 .COL0(C0), .COL_STEP(CSTEP), .TRANSPARENT(0), .BLINK_FRAMES(BF0))
    dut_opq (.clk(clk), .rst(rst), .newframe(newframe), .x(x), .y(y), .line(line),
             .blink_mask(blink_mask), .fg_rgb(fg_rgb), .vid_rgb(vid_rgb),
             .out_R(r0), .out_G(g0), .out_B(b0), .busy(busy0));

  text_overlay #(.N_CHARS(NC), .N_ROWS(NR), .ROW_Y0(Y0), .ROW_PITCH(PITCH),
                 .COL0(C0), .COL_STEP(CSTEP), .TRANSPARENT(1), .BLINK_FRAMES(BF1))
    dut_trn (.clk(clk), .rst(rst), .newframe(newframe), .x(x), .y(y), .line(line),
             .blink_mask(blink_mask), .fg_rgb(fg_rgb), .vid_rgb(vid_rgb),
             .out_R(r1), .out_G(g1), .out_B(b1), .busy(busy1));

  always #5 clk = ~clk;

  // Reference state: what the text buffer / blink looked like at the last frame start.
  logic [LW-1:0] m_line;
  logic [NR-1:0] m_blink;
  int            m_frames;
  logic [3:0]    pend0, pend1, exp0, exp1;   // {busy, rgb}
  int            vectors = 0;
  int            miscompares = 0;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] vid;
    logic [2:0] exp_opq;
    logic [2:0] exp_trn;
    logic       exp_busy;
  } vec_t;
  vec_t tbl [9];

  function automatic logic [3:0] model_pix(input bit transp, input int bf, input int xi,
                                           input int yi, input logic [2:0] vid,
                                           input logic [2:0] fg);
    int         start, d;
    logic [3:0] ch;
    logic [7:0] rowbits;
    for (int r = 0; r < NR; r++) begin
      start = Y0 + r * PITCH;
      if (yi >= start && yi < start + 8) begin
        d  = xi / 8 - C0;
        ch = CHAR_BLANK;
        if (d >= 0 && d % CSTEP == 0 && d / CSTEP < NC) ch = m_line[4 * (r * NC + d / CSTEP) +: 4];
        if (m_blink[r] && ((m_frames / bf) % 2 == 1)) ch = CHAR_BLANK;
        rowbits = FONT[ch][yi - start];
        if (rowbits[7 - (xi % 8)]) return {1'b1, fg};
        return {1'b1, transp ? vid : 3'b000};
      end
    end
    return {1'b0, vid};
  endfunction

  task automatic model_reset();
    m_line   = '1;
    m_blink  = '0;
    m_frames = 0;
    pend0 = '0; pend1 = '0; exp0 = '0; exp1 = '0;
  endtask

  // One clock: predict the current pixel, advance the expected pipeline, latch snapshot.
  task automatic tick();
    logic [3:0] p0, p1;
    p0 = model_pix(1'b0, BF0, int'(x), int'(y), vid_rgb, fg_rgb);
    p1 = model_pix(1'b1, BF1, int'(x), int'(y), vid_rgb, fg_rgb);
    @(posedge clk);
    exp0 = pend0; pend0 = p0;
    exp1 = pend1; pend1 = p1;
    if (newframe) begin
      m_line  = line;
      m_blink = blink_mask;
      m_frames++;
    end
    #1;
  endtask

  task automatic cmp(input string name, input logic [3:0] got, input logic [3:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s x=%0d y=%0d: got busy=%b rgb=%03b, want busy=%b rgb=%03b",
               name, x, y, got[3], got[2:0], want[3], want[2:0]);
    end
  endtask

  task automatic check(input string name);
    cmp({name, "/opq"}, {busy0, r0, g0, b0}, exp0);
    cmp({name, "/trn"}, {busy1, r1, g1, b1}, exp1);
  endtask

  task automatic scan(input string name, input int yv, input int xa, input int xb);
    for (int xv = xa; xv <= xb; xv++) begin
      x = 10'(xv); y = 10'(yv);
      tick();
      check(name);
    end
  endtask

  task automatic pulse_nf();
    newframe = 1'b1; x = 10'd0; y = 10'd0;
    tick();
    check("newframe");
    newframe = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  function automatic logic [LW-1:0] set_char(input logic [LW-1:0] l, input int r,
                                             input int k, input logic [3:0] c);
    logic [LW-1:0] t;
    t = l;
    t[4 * (r * NC + k) +: 4] = c;
    return t;
  endfunction

  initial begin
    tbl[0] = '{10'd5,    10'd10,   3'b101, 3'b101, 3'b101, 1'b0};
    tbl[1] = '{10'd100,  10'd199,  3'b101, 3'b101, 3'b101, 1'b0};
    tbl[2] = '{10'd16,   10'd200,  3'b101, 3'b000, 3'b101, 1'b1};
    tbl[3] = '{10'd40,   10'd207,  3'b110, 3'b000, 3'b110, 1'b1};
    tbl[4] = '{10'd8,    10'd208,  3'b011, 3'b011, 3'b011, 1'b0};
    tbl[5] = '{10'd0,    10'd209,  3'b111, 3'b000, 3'b111, 1'b1};
    tbl[6] = '{10'd600,  10'd216,  3'b101, 3'b000, 3'b101, 1'b1};
    tbl[7] = '{10'd12,   10'd217,  3'b010, 3'b010, 3'b010, 1'b0};
    tbl[8] = '{10'd1023, 10'd1023, 3'b111, 3'b111, 3'b111, 1'b0};

    newframe = 1'b0; x = '0; y = '0; line = '1; blink_mask = '0;
    fg_rgb = 3'b111; vid_rgb = 3'b101;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    cmp("reset_state/opq", {busy0, r0, g0, b0}, 4'b0000);
    cmp("reset_state/trn", {busy1, r1, g1, b1}, 4'b0000);
    rst = 1'b0;
    model_reset();

    // Fixed vectors with hand-derived results (text still blank after reset).
    for (int i = 0; i <= 9; i++) begin
      if (i < 9) begin
        x = tbl[i].x; y = tbl[i].y; vid_rgb = tbl[i].vid;
      end
      tick();
      if (i >= 1) begin
        cmp("table/opq", {busy1 & 1'b0 | busy0, r0, g0, b0}, {tbl[i-1].exp_busy, tbl[i-1].exp_opq});
        cmp("table/trn", {busy1, r1, g1, b1}, {tbl[i-1].exp_busy, tbl[i-1].exp_trn});
      end
    end

    // Default frame with vid 101 across the band edges.
    vid_rgb = 3'b101;
    for (int yv = 198; yv <= 218; yv++) begin
      scan("frame_default", yv, 8, 8);
      scan("frame_default", yv, 24, 24);
      scan("frame_default", yv, 100, 100);
    end

    // Glyph '1' in row 0 cell 0, row 3 scanned pixel by pixel.
    line = set_char('1, 0, 0, 4'd1);
    pulse_nf();
    fg_rgb = 3'b111;
    scan("glyph_row3", 203, 8, 15);

    // Blank cell 1 and the gap cell between cells.
    line = set_char(line, 0, 1, 4'hF);
    pulse_nf();
    vid_rgb = 3'b110;
    scan("blank_cell", 200, 24, 31);
    scan("gap_cell", 200, 16, 23);
    vid_rgb = 3'b011;
    scan("glyph_row0", 200, 8, 15);

    // Mid-frame buffer change must not tear the current frame.
    scan("midframe_old", 204, 8, 23);
    line = set_char(set_char(line, 0, 0, 4'd3), 0, 1, 4'd5);
    scan("midframe_held", 204, 8, 31);
    pulse_nf();
    scan("midframe_new", 204, 8, 31);

    // Blink: row 0 blinks, row 1 steady; frames counted from reset.
    do_reset();
    fg_rgb = 3'b010; vid_rgb = 3'b100;
    line = set_char(set_char('1, 0, 0, 4'd8), 1, 0, 4'd2);
    blink_mask = 2'b01;
    for (int f = 0; f < 7; f++) begin
      if (f > 0) pulse_nf();
      scan("blink_row0", 202, 8, 15);
      scan("blink_row1", 211, 8, 15);
    end

    // Asynchronous reset while a glyph pixel sits at the output.
    do_reset();
    fg_rgb = 3'b111;
    line = set_char('1, 0, 0, 4'd8);
    blink_mask = '0;
    pulse_nf();
    x = 10'd9; y = 10'd202;
    tick(); check("pre_rst");
    tick(); check("pre_rst");
    rst = 1'b1;
    #1;
    cmp("rst_async/opq", {busy0, r0, g0, b0}, 4'b0000);
    cmp("rst_async/trn", {busy1, r1, g1, b1}, 4'b0000);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    scan("post_rst_blank", 202, 8, 15);
    scan("post_rst_outside", 190, 8, 10);
    pulse_nf();
    scan("post_rst_text", 202, 8, 15);

    // Randomised traffic around the text area.
    for (int i = 0; i < 2000; i++) begin
      x = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 150));
      y = 10'($urandom_range(192, 222));
      vid_rgb = 3'($urandom);
      fg_rgb  = 3'($urandom);
      newframe = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 49) == 0) line = {$urandom, $urandom};
      if ($urandom_range(0, 49) == 0) blink_mask = 2'($urandom);
      tick();
      check("random");
    end
    newframe = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/text_overlay.md
# text_overlay

Parametrised text-overlay renderer in the VGA pixel path. It draws up to N_ROWS rows of N_CHARS 8×8 glyph cells at fixed screen positions over an incoming video underlay. It replaces the fixed two-row, newline-counted character painter with the following:
- a frame-synchronous snapshot of the text buffer,
- y-derived glyph rows,
- a registered 2-stage pipeline,
- foreground colour, opaque/transparent mode and per-row blink.

## Interface
- N_CHARS, 8: character cells per row
- N_ROWS, 2: text rows
- ROW_Y0, 200: first scanline of row 0
- ROW_PITCH, 9: scanlines between row starts (≥ 8)
- COL0, 1: x-cell index (x[9:3]) of cell 0
- COL_STEP, 2: x-cell stride between cells (≥ 1)
- TRANSPARENT, 0: 1 = background pixels pass the underlay, 0 = background forced black
- BLINK_FRAMES, 30: frames per blink half-period (≥ 1)

Ports:
- clk  in  1  pixel clock; one pixel per cycle
- rst  in  1  asynchronous, active-high reset
- newframe  in  1  one-cycle pulse at frame start
- x  in  10  current pixel column
- y  in  10  current scanline
- line  in  4·N_CHARS·N_ROWS  char indices; row r, cell k at bits [4(r·N_CHARS+k) +: 4]
- blink_mask  in  N_ROWS  1 = row blinks
- fg_rgb  in  3  glyph colour {R,G,B}
- vid_rgb  in  3  underlay pixel {R,G,B}, aligned with x/y
- out_R, out_G, out_B  out  1 each  composited pixel
- busy  out  1  output pixel lies inside a text row band

## Operation
- Snapshot:
  - On newframe, line and blink_mask are copied into internal registers.
  - Rendering uses only the snapshot, so a mid-frame change of line never tears.
- Row hit:
  - Row r is active when ROW_Y0 + r·ROW_PITCH ≤ y < ROW_Y0 + r·ROW_PITCH + 8.
  - Glyph row = y − row start (3 bits). There is no newline counter.
- Cell hit:
  - Cell k is active when x[9:3] == COL0 + k·COL_STEP and k < N_CHARS.
  - The char index comes from the snapshot. No cell hit gives index 4'hF (blank).
- Glyph:
  - pixel bit = glyph_row[7 − x[2:0]], read from the font ROM.
  - Index 15 is all zeros.
- Blink:
  - A frame counter counts newframe pulses from 0 to BLINK_FRAMES−1.
  - On wrap the counter returns to 0 and the phase toggles.
  - In the hidden phase, rows with their snapshot blink bit set render as background.
- Compositing:
  - Inside a row band: a glyph pixel outputs fg_rgb. Otherwise output vid_rgb if TRANSPARENT, else 000.
  - Outside all row bands: output vid_rgb.
- Overlapping bands (not possible with ROW_PITCH ≥ 8): lowest r wins.

## Timing
- Latency is 2 clk from x/y/vid_rgb to out_* and busy.
  - Stage 1 registers: row hit, glyph row, char index, x[2:0], delayed vid_rgb.
  - Stage 2 registers: the composited pixel and busy.
- Stage 1 uses the snapshot value present at the clock edge. If newframe and a pixel arrive in the same cycle, the pixel uses the old snapshot; the new snapshot applies from the next cycle.
- Blink phase update and snapshot load happen on the same newframe edge.
- Reset values:
  - out_R/G/B = 0, busy = 0
  - snapshot chars = 4'hF, blink snapshot = 0
  - frame counter = 0, phase = visible
  - all pipeline registers = 0
- Reset mid-frame: the outputs go to 0 immediately. Until the next newframe, text renders blank and the underlay still passes outside the bands (and inside them if TRANSPARENT).

## Structure
- text_overlay_pkg holds:
  - GLYPH_W = 8, GLYPH_H = 8
  - CHAR_BLANK = 4'hF
  - the 16×8 font table constant, which the bench also uses as its golden reference
- Sub-module char_glyph_rom (char[3:0], rownum[2:0] → pixels[7:0]) is combinational and reads the package table.
- The blink counter width is $clog2(BLINK_FRAMES).

## Test plan
- Reset, then run a frame with vid_rgb = 101 and defaults.
  - Every pixel outside y 200–207 and 209–216 outputs 101, with busy = 0.
  - busy = 1 for y in 200–207, delayed 2 clk.
- Load line row0 cell0 = 1, then pulse newframe. Scan y = 203, x = 8–15 with fg_rgb = 111 and TRANSPARENT = 0.
  - out equals font[1][3] bit-by-bit, MSB at x = 8: 111 for a set bit, 000 for a clear bit, with 2-clk latency.
- Set cell1 = 15 and TRANSPARENT = 1.
  - x = 24–31, y = 200 outputs vid_rgb unchanged.
  - x = 16–23 (gap cell) outputs vid_rgb.
- Change line mid-frame at y = 204.
  - Rendering is unchanged until the next newframe pulse; from that frame the new glyphs appear.
- BLINK_FRAMES = 2, blink_mask = 01.
  - Row 0 is visible for frames 0–1, hidden for frames 2–3, visible again for frames 4–5.
  - Row 1 is always visible.
- Assert rst at y = 202 while a glyph pixel is at the output.
  - out and busy go to 0 the same cycle.
  - After release, the text stays blank until newframe; the snapshot reads 4'hF.
